// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and widths for the pipeline stall/flush controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STALL_CNT_W = 32;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between ID/EX load and IF/ID sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       idex_memRead,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_usesRt,
  output logic       lu_hazard
);
  assign lu_hazard = idex_memRead && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (ifid_usesRt && (idex_rt == ifid_rt)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller with memory-wait FSM, timeout and stall counter
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 200,
  parameter int TO_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   idex_memRead,
  input  logic [4:0]             idex_rt,
  input  logic [4:0]             ifid_rs,
  input  logic [4:0]             ifid_rt,
  input  logic                   ifid_usesRt,
  input  logic                   ex_branchTaken,
  input  logic                   exmem_memAccess,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_write,
  output logic                   exmem_write,
  output logic                   memwb_write,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   memwb_flush,
  output logic                   dmem_req,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state
);
  state_t          st, st_n;
  logic [TO_W-1:0] to_cnt;
  logic            lu_hazard;
  logic            freeze;

  hazard_detect u_hazard_detect (
    .idex_memRead (idex_memRead),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_usesRt  (ifid_usesRt),
    .lu_hazard    (lu_hazard)
  );

  // In MEM_WAIT the access is still outstanding regardless of exmem_memAccess
  assign freeze = (st == ST_MEM_WAIT) ? !dmem_ready : (st == ST_RUN) && exmem_memAccess && !dmem_ready;

  always_comb begin
    st_n        = st;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    dmem_req    = exmem_memAccess;
    if (!rst) begin
      {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
      {ifid_flush, idex_flush, memwb_flush} = '1;
      dmem_req = 1'b0;
      st_n     = ST_RUN;
    end else if (st == ST_ERR) begin
      {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
      dmem_req = 1'b0;
    end else if (freeze) begin
      {pc_write, ifid_write, idex_write, exmem_write} = '0;
      memwb_flush = 1'b1;
      st_n = (st == ST_MEM_WAIT && to_cnt == TO_W'(MEM_TIMEOUT - 1)) ? ST_ERR : ST_MEM_WAIT;
    end else begin
      st_n = ST_RUN;
      if (ex_branchTaken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_hazard) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= ST_RUN;
      to_cnt    <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      st        <= st_n;
      to_cnt    <= (st == ST_MEM_WAIT && !dmem_ready) ? to_cnt + 1'b1 : '0;
      mem_err   <= mem_err | (st_n == ST_ERR);
      stall_cnt <= (!pc_write && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end

  assign state = st;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl (MEM_TIMEOUT=4)
module tb_pipeline_ctrl;
  logic        clk, rst;
  logic        idex_memRead, ifid_usesRt, ex_branchTaken, exmem_memAccess, dmem_ready;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic        ifid_flush, idex_flush, memwb_flush, dmem_req, mem_err;
  logic [31:0] stall_cnt;
  logic [1:0]  state;
  int          errs = 0, checks = 0;

  // {pc,ifid,idex,exmem,memwb writes, ifid,idex,memwb flushes, dmem_req}
  localparam logic [8:0] C_RUN  = 9'b11111_000_0;
  localparam logic [8:0] C_RUNR = 9'b11111_000_1;
  localparam logic [8:0] C_LU   = 9'b00111_010_0;
  localparam logic [8:0] C_BR   = 9'b11111_110_0;
  localparam logic [8:0] C_BRR  = 9'b11111_110_1;
  localparam logic [8:0] C_FRZ  = 9'b00001_001_1;
  localparam logic [8:0] C_ERR  = 9'b00000_000_0;
  localparam logic [8:0] C_RST  = 9'b00000_111_0;

  typedef struct packed {
    logic [8:0]  ctl;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  pipeline_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_usesRt(ifid_usesRt), .ex_branchTaken(ex_branchTaken),
    .exmem_memAccess(exmem_memAccess), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                     input logic [4:0] irt, input logic urt, input logic br,
                     input logic ma, input logic rdy);
    idex_memRead = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = irt;
    ifid_usesRt = urt; ex_branchTaken = br; exmem_memAccess = ma; dmem_ready = rdy;
  endtask

  // Called just after a negedge with inputs already driven; compares mid-low-phase
  task automatic step(input string tag, input logic [8:0] ectl, input logic [1:0] est,
                      input logic [31:0] ecnt);
    exp_t e;
    exp_q.push_back(exp_t'{ctl: ectl, st: est, cnt: ecnt});
    #2;
    e = exp_q.pop_front();
    chk({tag, ".ctl"}, {23'd0, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                        ifid_flush, idex_flush, memwb_flush, dmem_req}, {23'd0, e.ctl});
    chk({tag, ".state"}, {30'd0, state}, {30'd0, e.st});
    chk({tag, ".cnt"}, stall_cnt, e.cnt);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step("reset", C_RST, 0, 0);
    chk("reset.mem_err", {31'd0, mem_err}, 0);
    rst = 1'b1;
    step("idle", C_RUN, 0, 0);
    // load-use on rs, on rt, and the non-hazard variants
    set(1, 8, 8, 0, 0, 0, 0, 0);  step("lu_rs", C_LU, 0, 0);
    set(0, 8, 8, 0, 0, 0, 0, 0);  step("lu_done", C_RUN, 0, 1);
    set(1, 0, 0, 0, 1, 0, 0, 0);  step("lu_r0", C_RUN, 0, 1);
    set(1, 9, 3, 9, 1, 0, 0, 0);  step("lu_rt", C_LU, 0, 1);
    set(1, 9, 3, 9, 0, 0, 0, 0);  step("lu_rt_unused", C_RUN, 0, 2);
    set(1, 8, 8, 0, 0, 1, 0, 0);  step("branch_lu", C_BR, 0, 2);
    set(0, 0, 0, 0, 0, 0, 0, 0);  step("branch_done", C_RUN, 0, 2);
    // memory wait, ready 3 cycles after request
    set(0, 0, 0, 0, 0, 0, 1, 0);  step("mw0", C_FRZ, 0, 2);
    step("mw1", C_FRZ, 1, 3);
    step("mw2", C_FRZ, 1, 4);
    set(0, 0, 0, 0, 0, 0, 1, 1);  step("mw_rdy", C_RUNR, 1, 5);
    set(0, 0, 0, 0, 0, 0, 0, 0);  step("mw_done", C_RUN, 0, 5);
    // timeout into ERR
    set(0, 0, 0, 0, 0, 0, 1, 0);  step("to0", C_FRZ, 0, 5);
    step("to1", C_FRZ, 1, 6);
    step("to2", C_FRZ, 1, 7);
    step("to3", C_FRZ, 1, 8);
    chk("to3.mem_err", {31'd0, mem_err}, 0);
    step("to4", C_FRZ, 1, 9);
    set(0, 0, 0, 0, 0, 1, 1, 1);  step("err0", C_ERR, 2, 10);
    chk("err.mem_err", {31'd0, mem_err}, 1);
    step("err1", C_ERR, 2, 11);
    rst = 1'b0;                   step("err_rst", C_RST, 0, 0);
    chk("err_rst.mem_err", {31'd0, mem_err}, 0);
    rst = 1'b1;
    // ready on the final allowed wait cycle, with a taken branch in the same cycle
    set(0, 0, 0, 0, 0, 0, 1, 0);  step("rl0", C_FRZ, 0, 0);
    step("rl1", C_FRZ, 1, 1);
    step("rl2", C_FRZ, 1, 2);
    step("rl3", C_FRZ, 1, 3);
    set(0, 0, 0, 0, 0, 1, 1, 1);  step("rl_rdy", C_BRR, 1, 4);
    set(0, 0, 0, 0, 0, 0, 0, 0);  step("rl_done", C_RUN, 0, 4);
    chk("rl_done.mem_err", {31'd0, mem_err}, 0);
    // reset asserted mid-wait
    set(0, 0, 0, 0, 0, 0, 1, 0);  step("rw0", C_FRZ, 0, 4);
    step("rw1", C_FRZ, 1, 5);
    rst = 1'b0;                   step("rw_rst", C_RST, 0, 0);
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0);  step("rw_after", C_RUN, 0, 0);
    // saturation
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    set(0, 0, 0, 0, 0, 0, 1, 0);  step("sat0", C_FRZ, 0, 32'hFFFF_FFFE);
    step("sat1", C_FRZ, 1, 32'hFFFF_FFFF);
    step("sat2", C_FRZ, 1, 32'hFFFF_FFFF);
    set(0, 0, 0, 0, 0, 0, 1, 1);  step("sat_rdy", C_RUNR, 1, 32'hFFFF_FFFF);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It generates the per-stage `Write` enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus synchronous flush requests, from three hazard sources:
- load-use data hazards
- taken branches resolved in EX
- multi-cycle data-memory accesses

A 3-state FSM holds the pipeline during memory waits and enforces a memory timeout. The block also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 200: maximum number of MEM_WAIT cycles before the block enters ERR.
- `TO_W`, default 8: width of the timeout counter. Must satisfy `MEM_TIMEOUT < 2**TO_W`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `idex_memRead` in 1: ID/EX holds a load.
- `idex_rt` in 5: destination register of that load.
- `ifid_rs`, `ifid_rt` in 5 each: source registers of the instruction in IF/ID.
- `ifid_usesRt` in 1: the IF/ID instruction reads rt.
- `ex_branchTaken` in 1: a branch or jump resolved taken in EX this cycle.
- `exmem_memAccess` in 1: EX/MEM holds a lw or sw.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write`, `memwb_write` out 1 each: stage enables.
- `ifid_flush`, `idex_flush`, `memwb_flush` out 1 each: load a bubble (all-zero) at the next posedge. Flush has priority over Write.
- `dmem_req` out 1: memory access request, level signal.
- `mem_err` out 1: sticky timeout flag.
- `stall_cnt` out 32: saturating count of cycles with `pc_write=0`.
- `state` out 2: FSM state, for debug.

## Operation
States: RUN=0, MEM_WAIT=1, ERR=2.

**RUN** is evaluated in strict priority order; the default is all writes 1 and all flushes 0.
1. **Memory stall:** `exmem_memAccess & ~dmem_ready`.
   - `pc_write`, `ifid_write`, `idex_write`, `exmem_write` are 0.
   - `memwb_write=1` with `memwb_flush=1`.
   - Next state is MEM_WAIT.
   - Branch and load-use flushes are suppressed; the frozen instructions are re-evaluated on release.
2. **Taken branch:** `ex_branchTaken`.
   - `ifid_flush=1`, `idex_flush=1`.
   - All writes are 1, so the PC loads the target.
3. **Load-use hazard:** `idex_memRead & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_usesRt & idex_rt==ifid_rt))`.
   - `pc_write=0`, `ifid_write=0`, `idex_flush=1`; the other writes are 1.
   - State stays RUN.

`dmem_req = exmem_memAccess` in RUN and MEM_WAIT; `dmem_req=0` in ERR.

**MEM_WAIT**
- While `dmem_ready=0`: outputs are the same as rule 1, and the timeout counter increments.
- If the counter equals `MEM_TIMEOUT-1` and `dmem_ready=0`: next state is ERR.
- On `dmem_ready=1`:
  - outputs equal the RUN evaluation with rule 1 skipped, so branch and load-use hazards apply in the same cycle;
  - the counter clears;
  - next state is RUN.
- If `dmem_ready` arrives on the timeout cycle, ready wins and the FSM returns to RUN.

**ERR**
- All writes are 0 and all flushes are 0.
- `mem_err=1`.
- Exit only by reset.

**`stall_cnt`** increments on every posedge where `pc_write=0`, and holds at 0xFFFFFFFF.

## Timing
- Stage enables, flushes and `dmem_req` are combinational (Mealy) from state and inputs. They are valid before the posedge at which the pipeline registers sample them.
- `state`, the timeout counter, `mem_err` and `stall_cnt` are registered.
- Hazard penalties:
  - load-use: exactly 1 bubble;
  - taken branch: 2 bubbles;
  - memory access: N stall cycles for a `dmem_ready` arriving N cycles after the request.
- While `rst=0`:
  - state=RUN, timeout counter=0, `mem_err=0`, `stall_cnt=0`;
  - all writes 0, all flushes 1, `dmem_req=0`.
- Reset asserted mid-MEM_WAIT or in ERR aborts immediately to these values. Normal operation resumes at the first posedge after `rst` returns to 1.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - state encodings `ST_RUN`, `ST_MEM_WAIT`, `ST_ERR`;
  - `REG_ZERO=5'd0`;
  - `STALL_CNT_W=32`.
- Sub-module `hazard_detect` is the combinational load-use comparator. Inputs: `idex_memRead`, `idex_rt`, `ifid_rs`, `ifid_rt`, `ifid_usesRt`. Output: `lu_hazard`.
- The FSM, timeout counter and stall counter stay in `pipeline_ctrl`.

## Test plan
- **Load-use:** `idex_memRead=1`, `idex_rt=8`, `ifid_rs=8` → one cycle of `pc_write=0`, `ifid_write=0`, `idex_flush=1`; `stall_cnt` goes 0→1. Repeat with `idex_rt=0` → no stall.
- **Taken branch:** `ex_branchTaken=1` coincident with a load-use hazard → `ifid_flush=1`, `idex_flush=1`, `pc_write=1`; no load-use stall.
- **Memory wait:** `exmem_memAccess=1` with `dmem_ready` asserted 3 cycles later → 3 cycles of frozen writes with `memwb_flush=1` and `state=1`, then all writes 1 and `state=0`; `stall_cnt=3`.
- **Timeout:** `MEM_TIMEOUT=4`, `dmem_ready` held 0 → `state=2` and `mem_err=1` after 4 wait cycles; all writes stay 0. Variant with `dmem_ready=1` on the 4th cycle → return to RUN, `mem_err=0`.
- **Reset mid-wait:** drive `rst=0` during MEM_WAIT → immediately `state=0`, all flushes 1, `dmem_req=0`, `stall_cnt=0`.
- **Saturation:** force `stall_cnt` to 0xFFFFFFFE and hold a memory stall for 3 cycles → `stall_cnt` stays at 0xFFFFFFFF.
